fcsr_access_ctrl: RTL and testbench
===================================

// Module: fcsr_access_ctrl
// PURPOSE
//  Sequences every access to the FP CSR file (fflags/frm/fcsr) from two requesters:
//  Zicsr instructions and FPU retirement flag accrual. Tracks in-flight FPU ops,
//  ORs retired flags into a pending accumulator, and flushes it as a flag-only write.
//  Orders a CSR instruction after all older FPU ops have retired and flushed their flags.
//  Sits between decode/FPU and the CSR file; it drives the file's full write/read port.
// PARAMETERS
//  XLEN          32  data width of CSR read/write values
//  MAX_INFLIGHT  4   max FPU ops issued but not retired; CNT_W = $clog2(MAX_INFLIGHT+1)
// PORTS
//  i_clk            in   1      clock, all state on rising edge
//  i_rst_n          in   1      asynchronous active-low reset
//  i_fpu_issue      in   1      FPU op issued this cycle (honoured only if !o_fpu_stall)
//  o_fpu_stall      out  1      block FPU issue: inflight==MAX_INFLIGHT or state!=IDLE
//  i_fpu_done       in   1      FPU op retired this cycle
//  i_fpu_fflags     in   5      {nv,dz,of,uf,nx} of retiring op, valid with i_fpu_done
//  i_csr_req_valid  in   1      CSR instruction request
//  o_csr_req_ready  out  1      request accepted when valid&&ready
//  i_csr_addr       in   12     CSR address (001 fflags, 002 frm, 003 fcsr, others read 0)
//  i_csr_op         in   2      00 RW, 01 RS, 10 RC
//  i_csr_we         in   1      0 for RS/RC with rs1=x0 (read-only access)
//  i_csr_wdata      in   XLEN   Reg[rs1] or zext(uimm)
//  o_csr_rsp_valid  out  1      one-cycle pulse, old CSR value on o_csr_rsp_rdata
//  o_csr_rsp_rdata  out  XLEN   value read before the write
//  o_rf_addr        out  12     to CSR file
//  o_rf_op          out  2      to CSR file
//  o_rf_write       out  1      to CSR file
//  o_rf_fflags      out  5      to CSR file; nonzero = flag-accrue write (file ignores addr/data)
//  o_rf_wr_data     out  XLEN   to CSR file
//  i_rf_rd_data     in   XLEN   combinational read data from CSR file for o_rf_addr
// BEHAVIOUR
//  Reset: state=IDLE, inflight=0, pending=0, latched req=0, o_csr_rsp_valid=0,
//   o_csr_rsp_rdata=0, o_rf_* = 0, o_fpu_stall=0, o_csr_req_ready=1.
//  inflight: +1 on accepted issue, -1 on done, unchanged if both; done at 0 saturates (assertion).
//  pending: pending_n = (flush ? 0 : pending) | (i_fpu_done ? i_fpu_fflags : 0); flags never lost.
//  Flush: in IDLE or DRAIN with pending!=0 -> o_rf_write=1, o_rf_fflags=pending, o_rf_addr=001,
//   o_rf_wr_data=0, same cycle (combinational); pending cleared at edge.
//  Flag-only flushes never share a cycle with an instruction write (file would drop the instruction write).
//  FSM:
//   IDLE   : ready=1. On accept latch addr/op/we/wdata -> ACCESS if inflight==0 && pending==0
//            && !i_fpu_done, else DRAIN.
//   DRAIN  : wait; flush as above; -> ACCESS when inflight==0 && pending==0 && !i_fpu_done.
//   ACCESS : o_rf_addr/op=latched, o_rf_write=latched we, o_rf_fflags=0, wr_data=latched;
//            capture i_rf_rd_data into o_csr_rsp_rdata -> RESP. File updates at this edge.
//   RESP   : o_csr_rsp_valid=1 (no backpressure) -> IDLE.
//  Stall outside IDLE keeps later FPU ops from using a stale frm; issue cannot occur in ACCESS.
//  Best latency: accept cycle N, file write at end of N+1, rsp_valid in N+2.
//  Unknown address: access still performed; file returns 0 and ignores write.
//  Reset mid-operation: all state discarded, latched request dropped, no rsp issued.
// STRUCTURE
//  fcsr_pkg: CSR address constants (FFLAGS/FRM/FCSR), CSR op encodings, fflags struct
//   {nv,dz,of,uf,nx}, state enum {IDLE,DRAIN,ACCESS,RESP}; shared with the CSR file.
//  Sub-module fpu_flag_tracker: inflight counter + pending accumulator + flush clear input.
//  Top holds FSM, request latch, rf port mux, response register.
// TESTING
//  1 Idle CSRRW fcsr wdata=0xE1, inflight 0 -> rf write in N+1, rsp N+2 = old fcsr, frm=7 fflags=01.
//  2 Issue 2 FPU ops, CSRRS fflags accepted; dones at +3 (nx) and +5 (of) -> two flushes;
//    access after last flush; rsp rdata=0x05.
//  3 done with flags 0x10 in the same cycle a flush of 0x01 fires -> pending=0x10 next cycle,
//    flushed next cycle; fflags=0x11.
//  4 Issue 4 ops back-to-back -> o_fpu_stall=1 at inflight 4; issue+done same cycle keeps count.
//  5 CSRRC fflags we=0 -> o_rf_write=0 in ACCESS, rsp = current fflags, file unchanged.
//  6 Assert i_rst_n=0 during DRAIN -> all outputs at reset values, no rsp_valid after release.

Source files
------------

// File: rtl/fcsr_access_ctrl_pkg.sv
// FP CSR constants and types shared by the access controller and the CSR file.
// Pure declarations: no latency, no backpressure.
package fcsr_access_ctrl_pkg;

  localparam logic [11:0] CSR_FFLAGS = 12'h001;
  localparam logic [11:0] CSR_FRM    = 12'h002;
  localparam logic [11:0] CSR_FCSR   = 12'h003;

  typedef enum logic [1:0] {
    CSR_RW = 2'b00,
    CSR_RS = 2'b01,
    CSR_RC = 2'b10
  } csr_op_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    ACCESS,
    RESP
  } state_e;

  function automatic logic fflags_any(fflags_t f);
    return |f;
  endfunction

endpackage

// File: rtl/fcsr_access_ctrl_if.sv
// Decode/FPU/CSR-file signal bundle around the FP CSR access controller.
// Slave modport is the controller's view; master is the surrounding pipeline.
interface fcsr_access_ctrl_if #(
  parameter int XLEN = 32
);
  import fcsr_access_ctrl_pkg::*;

  logic            i_fpu_issue;
  logic            o_fpu_stall;
  logic            i_fpu_done;
  fflags_t         i_fpu_fflags;

  logic            i_csr_req_valid;
  logic            o_csr_req_ready;
  logic [11:0]     i_csr_addr;
  logic [1:0]      i_csr_op;
  logic            i_csr_we;
  logic [XLEN-1:0] i_csr_wdata;
  logic            o_csr_rsp_valid;
  logic [XLEN-1:0] o_csr_rsp_rdata;

  logic [11:0]     o_rf_addr;
  logic [1:0]      o_rf_op;
  logic            o_rf_write;
  fflags_t         o_rf_fflags;
  logic [XLEN-1:0] o_rf_wr_data;
  logic [XLEN-1:0] i_rf_rd_data;

  modport slave (
    input  i_fpu_issue, i_fpu_done, i_fpu_fflags,
    input  i_csr_req_valid, i_csr_addr, i_csr_op, i_csr_we, i_csr_wdata,
    input  i_rf_rd_data,
    output o_fpu_stall, o_csr_req_ready, o_csr_rsp_valid, o_csr_rsp_rdata,
    output o_rf_addr, o_rf_op, o_rf_write, o_rf_fflags, o_rf_wr_data
  );

  modport master (
    output i_fpu_issue, i_fpu_done, i_fpu_fflags,
    output i_csr_req_valid, i_csr_addr, i_csr_op, i_csr_we, i_csr_wdata,
    output i_rf_rd_data,
    input  o_fpu_stall, o_csr_req_ready, o_csr_rsp_valid, o_csr_rsp_rdata,
    input  o_rf_addr, o_rf_op, o_rf_write, o_rf_fflags, o_rf_wr_data
  );

endinterface

// File: rtl/fcsr_access_ctrl_fpu_flag_tracker.sv
// Counts FPU ops in flight and accumulates retired fflags until flushed.
// Updates one cycle after issue/done; no backpressure (caller gates issue).
module fpu_flag_tracker
  import fcsr_access_ctrl_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_issue,
  input  logic             i_done,
  input  fflags_t          i_fflags,
  input  logic             i_flush,
  output logic [CNT_W-1:0] o_inflight,
  output fflags_t          o_pending
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_inflight <= '0;
      o_pending  <= '0;
    end else begin
      case ({i_issue, i_done})
        2'b10:   o_inflight <= o_inflight + CNT_W'(1);
        2'b01:   if (o_inflight != '0) o_inflight <= o_inflight - CNT_W'(1);
        default: o_inflight <= o_inflight;
      endcase
      // A flag retiring in the flush cycle survives into the next accumulation.
      o_pending <= (i_flush ? fflags_t'('0) : o_pending) | (i_done ? i_fflags : fflags_t'('0));
    end
  end

  a_no_underflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_done && !i_issue && (o_inflight == '0)));

endmodule

// File: rtl/fcsr_access_ctrl.sv
// Orders Zicsr accesses to fflags/frm/fcsr behind older FPU ops and flushes accrued flags.
// Best case accept N, file write end of N+1, rsp N+2; ready only in IDLE, FPU issue stalled otherwise.
module fcsr_access_ctrl
  import fcsr_access_ctrl_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int MAX_INFLIGHT = 4
) (
  input logic               i_clk,
  input logic               i_rst_n,
  fcsr_access_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

  state_e           state;
  logic [11:0]      req_addr;
  logic [1:0]       req_op;
  logic             req_we;
  logic [XLEN-1:0]  req_wdata;
  logic             rsp_valid;
  logic [XLEN-1:0]  rsp_rdata;
  logic [CNT_W-1:0] inflight;
  fflags_t          pending;
  logic             flush;
  logic             issue_ok;
  logic             accept;
  logic             drained;

  assign flush    = ((state == IDLE) || (state == DRAIN)) && fflags_any(pending);
  assign issue_ok = bus.i_fpu_issue && !bus.o_fpu_stall;
  assign accept   = bus.i_csr_req_valid && bus.o_csr_req_ready;
  assign drained  = (inflight == '0) && !fflags_any(pending) && !bus.i_fpu_done;

  // Holding issue outside IDLE keeps younger ops from reading a frm about to change.
  assign bus.o_fpu_stall     = (inflight == CNT_W'(MAX_INFLIGHT)) || (state != IDLE);
  assign bus.o_csr_req_ready = (state == IDLE);
  assign bus.o_csr_rsp_valid = rsp_valid;
  assign bus.o_csr_rsp_rdata = rsp_rdata;

  fpu_flag_tracker #(
    .MAX_INFLIGHT (MAX_INFLIGHT),
    .CNT_W        (CNT_W)
  ) u_tracker (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_issue    (issue_ok),
    .i_done     (bus.i_fpu_done),
    .i_fflags   (bus.i_fpu_fflags),
    .i_flush    (flush),
    .o_inflight (inflight),
    .o_pending  (pending)
  );

  // Flush is never active in ACCESS, so a flag-only write cannot mask the instruction write.
  always_comb begin
    bus.o_rf_addr    = '0;
    bus.o_rf_op      = '0;
    bus.o_rf_write   = 1'b0;
    bus.o_rf_fflags  = '0;
    bus.o_rf_wr_data = '0;
    if (state == ACCESS) begin
      bus.o_rf_addr    = req_addr;
      bus.o_rf_op      = req_op;
      bus.o_rf_write   = req_we;
      bus.o_rf_wr_data = req_wdata;
    end else if (flush) begin
      bus.o_rf_addr    = CSR_FFLAGS;
      bus.o_rf_write   = 1'b1;
      bus.o_rf_fflags  = pending;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      req_addr  <= '0;
      req_op    <= '0;
      req_we    <= 1'b0;
      req_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            req_addr  <= bus.i_csr_addr;
            req_op    <= bus.i_csr_op;
            req_we    <= bus.i_csr_we;
            req_wdata <= bus.i_csr_wdata;
            state     <= drained ? ACCESS : DRAIN;
          end
        end
        DRAIN: begin
          if (drained) state <= ACCESS;
        end
        ACCESS: begin
          rsp_rdata <= bus.i_rf_rd_data;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fcsr_access_ctrl.sv
// Directed scenarios plus random traffic against a transaction-level model of the FP CSR state.
`timescale 1ns/1ps
module tb_fcsr_access_ctrl;
  import fcsr_access_ctrl_pkg::*;

  localparam int XLEN = 32;
  localparam int MAXI = 4;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  fcsr_access_ctrl_if #(.XLEN(XLEN)) bus ();

  fcsr_access_ctrl #(.XLEN(XLEN), .MAX_INFLIGHT(MAXI)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Architectural model: flags are ORed in at retirement, CSR ops applied when answered.
  logic [4:0]  m_ff  = 5'd0;
  logic [2:0]  m_frm = 3'd0;
  int          m_cnt = 0;
  bit          m_busy = 0;
  bit          m_acc = 0;
  bit          m_rsp = 0;
  int          busy_age = 0;
  logic [31:0] m_rdata;
  logic [11:0] q_addr;
  logic [1:0]  q_op;
  logic        q_we;
  logic [31:0] q_wdata;

  // CSR file attached to the port.
  logic [4:0] f_ff  = 5'd0;
  logic [2:0] f_frm = 3'd0;

  function automatic logic [31:0] csr_read(logic [4:0] ff, logic [2:0] frm, logic [11:0] a);
    case (a)
      12'h001: return {27'd0, ff};
      12'h002: return {29'd0, frm};
      12'h003: return {24'd0, frm, ff};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [7:0] csr_next(logic [4:0] ff, logic [2:0] frm, logic [11:0] a,
                                          logic [1:0] op, logic [31:0] wd);
    logic [31:0] old;
    logic [31:0] nv;
    old = csr_read(ff, frm, a);
    case (op)
      2'b00:   nv = wd;
      2'b01:   nv = old | wd;
      2'b10:   nv = old & ~wd;
      default: nv = old;
    endcase
    case (a)
      12'h001: return {frm, nv[4:0]};
      12'h002: return {nv[2:0], ff};
      12'h003: return nv[7:0];
      default: return {frm, ff};
    endcase
  endfunction

  always_comb bus.i_rf_rd_data = csr_read(f_ff, f_frm, bus.o_rf_addr);

  always @(posedge i_clk) begin
    if (bus.o_rf_write) begin
      if (bus.o_rf_fflags != 5'd0) f_ff <= f_ff | bus.o_rf_fflags;
      else {f_frm, f_ff} <= csr_next(f_ff, f_frm, bus.o_rf_addr, bus.o_rf_op, bus.o_rf_wr_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_stall"}, bus.o_fpu_stall, 0);
    chk({tag, "_ready"}, bus.o_csr_req_ready, 1);
    chk({tag, "_rsp_valid"}, bus.o_csr_rsp_valid, 0);
    chk({tag, "_rsp_rdata"}, bus.o_csr_rsp_rdata, 0);
    chk({tag, "_rf_ctl"}, {bus.o_rf_write, bus.o_rf_addr, bus.o_rf_op, bus.o_rf_fflags}, 0);
    chk({tag, "_rf_wdata"}, bus.o_rf_wr_data, 0);
  endtask

  task automatic set_req(input logic [11:0] a, input logic [1:0] op, input logic we,
                         input logic [31:0] wd);
    bus.i_csr_req_valid = 1'b1;
    bus.i_csr_addr      = a;
    bus.i_csr_op        = op;
    bus.i_csr_we        = we;
    bus.i_csr_wdata     = wd;
  endtask

  // Check the current cycle at the falling edge, then advance the model past the rising edge.
  task automatic to_neg();
    logic exp_stall;
    @(negedge i_clk);
    exp_stall = (m_cnt == MAXI) || m_busy;
    chk("stall", bus.o_fpu_stall, exp_stall);
    chk("ready", bus.o_csr_req_ready, !m_busy);
    if (bus.o_rf_write && bus.o_rf_fflags == 5'd0)
      chk("instr_wr_order", {(m_cnt == 0), f_ff}, {1'b1, m_ff});
    m_rsp = bus.o_csr_rsp_valid;
    if (m_rsp) begin
      chk("rsp_while_busy", m_busy, 1);
      chk("rsp_rdata", bus.o_csr_rsp_rdata, csr_read(m_ff, m_frm, q_addr));
      m_rdata = bus.o_csr_rsp_rdata;
      if (q_we) {m_frm, m_ff} = csr_next(m_ff, m_frm, q_addr, q_op, q_wdata);
    end
    m_acc = bus.i_csr_req_valid && !m_busy;
    if (bus.i_fpu_issue && !exp_stall) m_cnt++;
    if (bus.i_fpu_done) begin
      m_cnt--;
      m_ff = m_ff | bus.i_fpu_fflags;
    end
    if (m_rsp) m_busy = 0;
    if (m_acc) begin
      m_busy   = 1;
      busy_age = 0;
      q_addr   = bus.i_csr_addr;
      q_op     = bus.i_csr_op;
      q_we     = bus.i_csr_we;
      q_wdata  = bus.i_csr_wdata;
    end
    if (m_busy) begin
      busy_age++;
      if (busy_age > 60) begin
        n_cmp++;
        n_bad++;
        $error("FAIL rsp_timeout waited=%0d cycles limit=60", busy_age);
        m_busy = 0;
      end
    end
  endtask

  task automatic to_pos();
    @(posedge i_clk);
    #1;
  endtask

  task automatic tick();
    to_neg();
    to_pos();
  endtask

  task automatic do_csr(input logic [11:0] a, input logic [1:0] op, input logic we,
                        input logic [31:0] wd, output logic [31:0] rd);
    set_req(a, op, we, wd);
    rd = 32'hDEAD_BEEF;
    for (int c = 0; c < 40; c++) begin
      to_neg();
      to_pos();
      if (m_acc) bus.i_csr_req_valid = 1'b0;
      if (m_rsp) begin
        rd = m_rdata;
        break;
      end
    end
    bus.i_csr_req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [4:0]  fl [2];
    int          nfl;
    bit          got;
    logic [11:0] addrs [4];
    addrs[0] = 12'h001; addrs[1] = 12'h002; addrs[2] = 12'h003; addrs[3] = 12'h7C0;

    bus.i_fpu_issue = 1'b0;
    bus.i_fpu_done = 1'b0;
    bus.i_fpu_fflags = '0;
    bus.i_csr_req_valid = 1'b0;
    bus.i_csr_addr = '0;
    bus.i_csr_op = '0;
    bus.i_csr_we = 1'b0;
    bus.i_csr_wdata = '0;

    repeat (3) @(posedge i_clk);
    #1;
    chk_reset("reset");
    i_rst_n = 1'b1;

    // 1: CSRRW fcsr with nothing in flight, best-case latency
    set_req(12'h003, 2'b00, 1'b1, 32'h0000_00E1);
    to_neg();
    to_pos();
    bus.i_csr_req_valid = 1'b0;
    to_neg();
    chk("t1_rf_ctl", {bus.o_rf_write, bus.o_rf_addr, bus.o_rf_op, bus.o_rf_fflags},
        {1'b1, 12'h003, 2'b00, 5'd0});
    chk("t1_rf_wdata", bus.o_rf_wr_data, 32'hE1);
    to_pos();
    to_neg();
    chk("t1_rsp_valid", bus.o_csr_rsp_valid, 1);
    chk("t1_rsp_rdata", bus.o_csr_rsp_rdata, 0);
    to_pos();
    chk("t1_file", {f_frm, f_ff}, 8'hE1);

    // 2: CSRRS fflags waits behind two in-flight ops and their flushes
    bus.i_fpu_issue = 1'b1;
    tick();
    tick();
    bus.i_fpu_issue = 1'b0;
    set_req(12'h001, 2'b01, 1'b0, 32'h0);
    to_neg();
    to_pos();
    bus.i_csr_req_valid = 1'b0;
    nfl = 0;
    got = 0;
    rd = '0;
    fl[0] = '0;
    fl[1] = '0;
    for (int c = 1; c <= 30 && !got; c++) begin
      bus.i_fpu_done   = (c == 3) || (c == 5);
      bus.i_fpu_fflags = (c == 3) ? 5'h01 : ((c == 5) ? 5'h04 : 5'h00);
      to_neg();
      if (bus.o_rf_write && bus.o_rf_fflags != 5'd0) begin
        if (nfl < 2) fl[nfl] = bus.o_rf_fflags;
        nfl++;
      end
      if (bus.o_csr_rsp_valid) begin
        got = 1;
        rd  = bus.o_csr_rsp_rdata;
      end
      to_pos();
    end
    bus.i_fpu_done = 1'b0;
    bus.i_fpu_fflags = '0;
    chk("t2_rsp_seen", got, 1);
    chk("t2_flush_count", nfl, 2);
    chk("t2_flush0", fl[0], 5'h01);
    chk("t2_flush1", fl[1], 5'h04);
    chk("t2_rsp_rdata", rd, 32'h05);

    // 3: retirement coincides with a flush; neither flag is lost
    do_csr(12'h001, 2'b00, 1'b1, 32'h0, rd);
    chk("t3_clear_rsp", rd, 32'h05);
    bus.i_fpu_issue = 1'b1;
    tick();
    tick();
    bus.i_fpu_issue = 1'b0;
    bus.i_fpu_done = 1'b1;
    bus.i_fpu_fflags = 5'h01;
    tick();
    bus.i_fpu_fflags = 5'h10;
    to_neg();
    chk("t3_flush_a", {bus.o_rf_write, bus.o_rf_fflags}, {1'b1, 5'h01});
    to_pos();
    bus.i_fpu_done = 1'b0;
    bus.i_fpu_fflags = '0;
    to_neg();
    chk("t3_flush_b", {bus.o_rf_write, bus.o_rf_addr, bus.o_rf_fflags}, {1'b1, 12'h001, 5'h10});
    to_pos();
    tick();
    chk("t3_file_fflags", f_ff, 5'h11);

    // 4: in-flight limit and simultaneous issue/done
    bus.i_fpu_issue = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    to_neg();
    chk("t4_stall_full", bus.o_fpu_stall, 1);
    to_pos();
    bus.i_fpu_done = 1'b1;
    tick();
    to_neg();
    chk("t4_stall_issue_done", bus.o_fpu_stall, 0);
    to_pos();
    bus.i_fpu_issue = 1'b0;
    bus.i_fpu_done = 1'b0;
    to_neg();
    chk("t4_count_kept", bus.o_fpu_stall, 0);
    to_pos();
    bus.i_fpu_issue = 1'b1;
    tick();
    bus.i_fpu_issue = 1'b0;
    to_neg();
    chk("t4_refill", bus.o_fpu_stall, 1);
    to_pos();
    bus.i_fpu_done = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    bus.i_fpu_done = 1'b0;
    tick();

    // 5: read-only CSRRC fflags leaves the file alone
    set_req(12'h001, 2'b10, 1'b0, 32'h1F);
    to_neg();
    to_pos();
    bus.i_csr_req_valid = 1'b0;
    to_neg();
    chk("t5_rf_ctl", {bus.o_rf_write, bus.o_rf_addr}, {1'b0, 12'h001});
    to_pos();
    to_neg();
    chk("t5_rsp", {bus.o_csr_rsp_valid, bus.o_csr_rsp_rdata}, {1'b1, 32'h11});
    to_pos();
    chk("t5_file", {f_frm, f_ff}, 8'hF1);

    // 6: reset while draining drops the request
    bus.i_fpu_issue = 1'b1;
    tick();
    bus.i_fpu_issue = 1'b0;
    set_req(12'h003, 2'b00, 1'b1, 32'hFF);
    to_neg();
    to_pos();
    bus.i_csr_req_valid = 1'b0;
    tick();
    #2;
    i_rst_n = 1'b0;
    #1;
    chk_reset("t6_reset");
    m_cnt = 0;
    m_busy = 0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    got = 0;
    for (int i = 0; i < 8; i++) begin
      to_neg();
      if (bus.o_csr_rsp_valid) got = 1;
      to_pos();
    end
    chk("t6_no_rsp", got, 0);
    chk("t6_file", {f_frm, f_ff}, 8'hF1);

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      if (!bus.i_csr_req_valid && !m_busy && $urandom_range(0, 7) == 0)
        set_req(addrs[$urandom_range(0, 3)], 2'($urandom_range(0, 2)),
                1'($urandom_range(0, 1)), $urandom);
      bus.i_fpu_issue  = !bus.i_csr_req_valid && ($urandom_range(0, 2) == 0);
      bus.i_fpu_done   = (m_cnt > 0) && ($urandom_range(0, 2) == 0);
      bus.i_fpu_fflags = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
      to_neg();
      to_pos();
      if (m_acc) bus.i_csr_req_valid = 1'b0;
    end
    bus.i_fpu_issue = 1'b0;
    bus.i_csr_req_valid = 1'b0;
    for (int c = 0; c < 100 && (m_cnt > 0 || m_busy); c++) begin
      bus.i_fpu_done   = (m_cnt > 0);
      bus.i_fpu_fflags = 5'($urandom);
      tick();
    end
    bus.i_fpu_done = 1'b0;
    bus.i_fpu_fflags = '0;
    repeat (3) tick();
    chk("final_file", {f_frm, f_ff}, {m_frm, m_ff});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
